const_seq: RTL and testbench
============================

# const_seq

Programmable constant-sequence source. For each trigger token accepted on `din`, it emits a configured sequence of 1..DEPTH constants on `dout` as a Queue: the data field is followed by an `eot` bit, which is set on the last element. The sequence table is loaded at run time over a `cfg` handshake interface. The block sits where a static constant source is too rigid, for example generating coefficient or header bursts per incoming event.

## Interface
- `DIN`, 1: trigger data width. The trigger payload is ignored.
- `TOUT`, 16: constant width. `dout_data` is TOUT+1 bits wide.
- `DEPTH`, 8: table entries. Must be a power of 2 and ≥2. AW = clog2(DEPTH).

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `din_valid` input 1: trigger valid.
- `din_ready` output 1: trigger accepted.
- `din_data` input DIN: ignored.
- `cfg_valid` input 1: config write valid.
- `cfg_ready` output 1: config write accepted.
- `cfg_data` input TOUT+AW+1: bits [TOUT-1:0] are the value, [TOUT+AW-1:TOUT] the index, and the MSB is the `last` flag.
- `dout_valid` output 1: element valid.
- `dout_ready` input 1: element consumed.
- `dout_data` output TOUT+1: [TOUT-1:0] is the constant and [TOUT] is `eot`.

## Operation
- States:
  - IDLE: no sequence in progress.
  - EMIT: sequence output in progress; `ptr` is the current element index.
- Registers:
  - `table[DEPTH]` of TOUT bits.
  - `last_idx` of AW bits.
  - `ptr` of AW bits.
- Reset values:
  - `table` = 0, `last_idx` = 0, `ptr` = 0, state = IDLE.
  - `dout_valid` = 0, `din_ready` = 0 while rst is low, `cfg_ready` = 0 while rst is low.
- IDLE:
  - `cfg_ready` = 1.
  - `din_ready` = ~`cfg_valid`; config has priority when both are valid.
- Config write (`cfg_valid & cfg_ready`):
  - `table[index]` ← value.
  - If `last` = 1, `last_idx` ← index.
  - A write with `last` = 0 leaves `last_idx` unchanged.
- Trigger (`din_valid & din_ready`): `ptr` ← 0, state → EMIT.
- EMIT:
  - `din_ready` = 0 and `cfg_ready` = 0; table writes are locked out for the whole sequence.
  - `dout_valid` = 1.
  - `dout_data` = {`ptr`==`last_idx`, `table[ptr]`}.
- On each `dout` handshake:
  - If `ptr` == `last_idx`, state → IDLE.
  - Otherwise `ptr` ← `ptr`+1; no wrap is possible because `ptr` ≤ `last_idx` < DEPTH.
- Holding `dout_ready` = 0 stalls the sequence. `dout_data` and `dout_valid` stay stable while stalled (AXI-style valid hold).
- The sequence length is `last_idx`+1. After reset the block emits a single element: value 0 with `eot` = 1.
- An asynchronous reset during EMIT aborts the sequence immediately. `dout_valid` drops with no `eot` emitted, and the table and `last_idx` revert to 0.

## Timing
- Without the register option:
  - Trigger accepted in cycle T; element 0 is valid in T+1.
  - At full `dout_ready`, element k is valid in T+1+k.
  - The last handshake is in cycle L; `din_ready` can return in L+1.
  - Peak rate: `last_idx`+2 cycles per trigger.
- A config write accepted in cycle C is visible to a trigger accepted in C+1 or later.
- No combinational path from `dout_ready` to `din_ready` or to `cfg_ready`.

## Configuration
- `CONST_SEQ_OREG_EN` defined:
  - `dout` is driven from a one-entry output register with a skid slot. It breaks the timing path from the table read mux, and `dout_ready` no longer combinationally affects internal state.
  - Element 0 arrives at T+2. Steady-state throughput stays at 1 element/cycle.
  - IDLE is re-entered only after the output register drains the `eot` element.
- `CONST_SEQ_OREG_EN` undefined: the behaviour described under Timing applies. `dout_data` comes combinationally from `table[ptr]`.

## Structure
- Package `const_seq_pkg` contains:
  - the state enum `const_seq_state_t` (IDLE, EMIT);
  - localparam functions for the `cfg_data` field offsets (value LSB, index LSB, last bit);
  - the `eot` bit position.
- Sub-module `const_seq_table` is the DEPTH×TOUT register file. It has one write port (`cfg`) and one asynchronous read port (`ptr`) and holds `last_idx`.
- The top level holds the FSM, `ptr`, handshake logic, and the optional output register.

## Test plan
- Post-reset trigger with `dout_ready` = 1 → one element, `dout_data` = {1, 0x0000}, `dout_valid` high exactly 1 cycle.
- Load the table with 0x0011, 0x0022, 0x0033, setting `last` on index 2, then trigger → {0,0x0011}, {0,0x0022}, {1,0x0033} in consecutive cycles; `din_ready` low during the burst.
- Same sequence with `dout_ready` toggled 1,0,0,1,… → no element lost or duplicated, and `dout_data` stable while stalled.
- `cfg_valid` and `din_valid` both high in IDLE → config accepted first; the trigger is accepted next cycle and uses the new value.
- `cfg_valid` asserted during EMIT → `cfg_ready` = 0 until after the `eot` handshake; the current sequence is unchanged.
- rst low for 1 cycle mid-sequence (after element 1) → `dout_valid` drops asynchronously; the next trigger emits {1,0x0000}.

Source files
------------

// File: rtl/const_seq_pkg.sv
// Shared types and field positions for the const_seq constant-sequence source.
package const_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } const_seq_state_t;

    // cfg_data layout: {last, index[AW-1:0], value[TOUT-1:0]}
    function automatic int unsigned cfg_val_lsb();
        return 0;
    endfunction

    function automatic int unsigned cfg_idx_lsb(input int unsigned tout);
        return tout;
    endfunction

    function automatic int unsigned cfg_last_bit(input int unsigned tout, input int unsigned aw);
        return tout + aw;
    endfunction

    // dout_data layout: {eot, value[TOUT-1:0]}
    function automatic int unsigned eot_bit(input int unsigned tout);
        return tout;
    endfunction

endpackage

// File: rtl/const_seq_table.sv
// DEPTH x TOUT constant table with one write port, one async read port and the
// sequence end index.
module const_seq_table #(
    parameter int unsigned TOUT  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [AW-1:0]   widx_i,
    input  logic [TOUT-1:0] wdata_i,
    input  logic            wlast_i,
    input  logic [AW-1:0]   ridx_i,
    output logic [TOUT-1:0] rdata_o,
    output logic [AW-1:0]   last_idx_o
);

    logic [TOUT-1:0] mem_q [DEPTH];
    logic [AW-1:0]   last_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_idx_q <= '0;
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
            if (wlast_i) begin
                last_idx_q <= widx_i;
            end
        end
    end

    assign rdata_o    = mem_q[ridx_i];
    assign last_idx_o = last_idx_q;

endmodule

// File: rtl/const_seq.sv
// Programmable constant-sequence source: each accepted trigger emits table[0..last_idx]
// with eot on the last element. Define CONST_SEQ_OREG_EN for a registered, skid-buffered dout.
module const_seq
    import const_seq_pkg::*;
#(
    parameter int unsigned DIN   = 1,
    parameter int unsigned TOUT  = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic [DIN-1:0]               din_data,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [TOUT+$clog2(DEPTH):0]  cfg_data,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [TOUT:0]                dout_data
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned VAL_LSB  = cfg_val_lsb();
    localparam int unsigned IDX_LSB  = cfg_idx_lsb(TOUT);
    localparam int unsigned LAST_BIT = cfg_last_bit(TOUT, AW);
    localparam int unsigned EOT_BIT  = eot_bit(TOUT);

    const_seq_state_t state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW-1:0]    last_idx;
    logic [TOUT-1:0]  rd_data;
    logic [TOUT:0]    src_data;
    logic             in_idle;
    logic             cfg_fire;
    logic             trig_fire;
    logic             src_valid;
    logic             src_ready;
    logic             src_fire;
    logic             src_last;
    logic             seq_done;
    logic             unused_din;

    assign unused_din = ^din_data;

    // Ready depends only on state and cfg_valid, never on dout_ready.
    assign in_idle   = (state_q == IDLE);
    assign cfg_ready = rst & in_idle;
    assign din_ready = rst & in_idle & ~cfg_valid;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign trig_fire = din_valid & din_ready;

    const_seq_table #(
        .TOUT  (TOUT),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst),
        .we_i       (cfg_fire),
        .widx_i     (cfg_data[IDX_LSB +: AW]),
        .wdata_i    (cfg_data[VAL_LSB +: TOUT]),
        .wlast_i    (cfg_data[LAST_BIT]),
        .ridx_i     (ptr_q),
        .rdata_o    (rd_data),
        .last_idx_o (last_idx)
    );

    assign src_last = (ptr_q == last_idx);
    assign src_fire = src_valid & src_ready;

    always_comb begin
        src_data              = '0;
        src_data[TOUT-1:0]    = rd_data;
        src_data[EOT_BIT]     = src_last;
    end

`ifdef CONST_SEQ_OREG_EN
    // Two-entry output stage: buf0 drives dout, buf1 absorbs one element in flight.
    logic [TOUT:0] buf0_q, buf0_d;
    logic [TOUT:0] buf1_q, buf1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          issued_q, issued_d;
    logic          pop;

    assign pop        = (cnt_q != 2'd0) & dout_ready;
    assign src_valid  = (state_q == EMIT) & ~issued_q;
    assign src_ready  = (cnt_q != 2'd2);
    assign seq_done   = issued_q & (cnt_q == 2'd0);
    assign dout_valid = (cnt_q != 2'd0);
    assign dout_data  = buf0_q;

    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        case ({src_fire, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    buf0_d = src_data;
                end else begin
                    buf1_d = src_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = src_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = src_data;
                end
            end
            default: ;
        endcase
        if (src_fire && src_last) begin
            issued_d = 1'b1;
        end
        if (seq_done) begin
            issued_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf0_q   <= '0;
            buf1_q   <= '0;
            cnt_q    <= '0;
            issued_q <= 1'b0;
        end else begin
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
        end
    end
`else
    assign src_valid  = (state_q == EMIT);
    assign src_ready  = dout_ready;
    assign seq_done   = src_fire & src_last;
    assign dout_valid = src_valid;
    assign dout_data  = src_data;
`endif

    // Sequencer: walk ptr from 0 to last_idx, one step per accepted element.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (trig_fire) begin
                    ptr_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (src_fire && !src_last) begin
                    ptr_d = ptr_q + AW'(1);
                end
                if (seq_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_const_seq.sv
// Directed self-checking bench for const_seq in its default (unregistered dout) build.
module tb_const_seq;

    logic        clk;
    logic        rst;
    logic        din_valid;
    logic        din_ready;
    logic [0:0]  din_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [19:0] cfg_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [16:0] dout_data;

    int pass_cnt;
    int total_cnt;

    logic [16:0] exp_seq [3];

    const_seq dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle config write, issued at a falling edge while IDLE.
    task automatic cfg_write(input logic [2:0] idx, input logic [15:0] val, input logic last);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = {last, idx, val};
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Trigger for one cycle; returns at the falling edge of the first EMIT cycle.
    task automatic trigger();
        @(negedge clk);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        din_valid  = 1'b1;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        din_data   = '0;
        dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if (din_ready !== 1'b0) $display("FAIL rst_din_ready: got %b want 0", din_ready); else pass_cnt++;
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL rst_cfg_ready: got %b want 0", cfg_ready); else pass_cnt++;
        total_cnt++;
        if (dout_valid !== 1'b0) $display("FAIL rst_dout_valid: got %b want 0", dout_valid); else pass_cnt++;
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        total_cnt++;
        if (din_ready !== 1'b1) $display("FAIL idle_din_ready: got %b want 1", din_ready); else pass_cnt++;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL idle_cfg_ready: got %b want 1", cfg_ready); else pass_cnt++;
    endtask

    task automatic test_post_reset_trigger();
        dout_ready = 1'b1;
        trigger();
        #1;
        total_cnt++;
        if (dout_valid !== 1'b1) $display("FAIL prt_valid: got %b want 1", dout_valid); else pass_cnt++;
        total_cnt++;
        if (dout_data !== 17'h10000) $display("FAIL prt_data: got %h want 10000", dout_data); else pass_cnt++;
        total_cnt++;
        if (din_ready !== 1'b0) $display("FAIL prt_din_ready: got %b want 0", din_ready); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (dout_valid !== 1'b0) $display("FAIL prt_valid_drop: got %b want 0", dout_valid); else pass_cnt++;
        total_cnt++;
        if (din_ready !== 1'b1) $display("FAIL prt_din_ready_back: got %b want 1", din_ready); else pass_cnt++;
    endtask

    task automatic test_burst();
        cfg_write(3'd0, 16'h0011, 1'b0);
        cfg_write(3'd1, 16'h0022, 1'b0);
        cfg_write(3'd2, 16'h0033, 1'b1);
        dout_ready = 1'b1;
        trigger();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            total_cnt++;
            if (dout_valid !== 1'b1) $display("FAIL burst_valid[%0d]: got %b want 1", k, dout_valid); else pass_cnt++;
            total_cnt++;
            if (dout_data !== exp_seq[k]) $display("FAIL burst_data[%0d]: got %h want %h", k, dout_data, exp_seq[k]); else pass_cnt++;
            total_cnt++;
            if (din_ready !== 1'b0) $display("FAIL burst_din_ready[%0d]: got %b want 0", k, din_ready); else pass_cnt++;
        end
        @(negedge clk);
        #1;
        total_cnt++;
        if (dout_valid !== 1'b0) $display("FAIL burst_end_valid: got %b want 0", dout_valid); else pass_cnt++;
    endtask

    task automatic test_stall();
        int k;
        k = 0;
        trigger();
        for (int c = 0; c < 30 && k < 3; c++) begin
            if (c > 0) @(negedge clk);
            dout_ready = (c % 3 == 0);
            #1;
            total_cnt++;
            if (dout_valid !== 1'b1) $display("FAIL stall_valid[c%0d]: got %b want 1", c, dout_valid); else pass_cnt++;
            total_cnt++;
            if (dout_data !== exp_seq[k]) $display("FAIL stall_data[c%0d]: got %h want %h", c, dout_data, exp_seq[k]); else pass_cnt++;
            if (dout_ready) k++;
        end
        total_cnt++;
        if (k !== 3) $display("FAIL stall_count: got %0d elements want 3", k); else pass_cnt++;
        @(negedge clk);
        dout_ready = 1'b1;
        #1;
        total_cnt++;
        if (dout_valid !== 1'b0) $display("FAIL stall_no_dup: got %b want 0", dout_valid); else pass_cnt++;
    endtask

    task automatic test_priority();
        dout_ready = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = {1'b1, 3'd0, 16'h00AB};
        din_valid = 1'b1;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL prio_cfg_ready: got %b want 1", cfg_ready); else pass_cnt++;
        total_cnt++;
        if (din_ready !== 1'b0) $display("FAIL prio_din_blocked: got %b want 0", din_ready); else pass_cnt++;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        total_cnt++;
        if (din_ready !== 1'b1) $display("FAIL prio_din_next: got %b want 1", din_ready); else pass_cnt++;
        @(negedge clk);
        din_valid = 1'b0;
        #1;
        total_cnt++;
        if (dout_data !== 17'h100AB || dout_valid !== 1'b1)
            $display("FAIL prio_new_value: got valid=%b data=%h want valid=1 data=100ab", dout_valid, dout_data);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (dout_valid !== 1'b0) $display("FAIL prio_single: got %b want 0", dout_valid); else pass_cnt++;
    endtask

    task automatic test_cfg_locked();
        cfg_write(3'd0, 16'h0011, 1'b0);
        cfg_write(3'd2, 16'h0033, 1'b1);
        dout_ready = 1'b0;
        trigger();
        cfg_valid = 1'b1;
        cfg_data  = {1'b1, 3'd0, 16'hFFFF};
        for (int s = 0; s < 2; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            total_cnt++;
            if (cfg_ready !== 1'b0) $display("FAIL lock_cfg_ready_stall[%0d]: got %b want 0", s, cfg_ready); else pass_cnt++;
            total_cnt++;
            if (dout_data !== exp_seq[0]) $display("FAIL lock_data_stall[%0d]: got %h want %h", s, dout_data, exp_seq[0]); else pass_cnt++;
        end
        @(negedge clk);
        dout_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            total_cnt++;
            if (cfg_ready !== 1'b0) $display("FAIL lock_cfg_ready[%0d]: got %b want 0", k, cfg_ready); else pass_cnt++;
            total_cnt++;
            if (dout_data !== exp_seq[k]) $display("FAIL lock_data[%0d]: got %h want %h", k, dout_data, exp_seq[k]); else pass_cnt++;
        end
        @(negedge clk);
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL lock_cfg_after: got %b want 1", cfg_ready); else pass_cnt++;
        total_cnt++;
        if (din_ready !== 1'b0) $display("FAIL lock_din_after: got %b want 0", din_ready); else pass_cnt++;
        @(negedge clk);
        cfg_valid = 1'b0;
        trigger();
        #1;
        total_cnt++;
        if (dout_data !== 17'h1FFFF) $display("FAIL lock_late_write: got %h want 1ffff", dout_data); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (dout_valid !== 1'b0) $display("FAIL lock_late_single: got %b want 0", dout_valid); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        cfg_write(3'd0, 16'h0011, 1'b0);
        cfg_write(3'd1, 16'h0022, 1'b0);
        cfg_write(3'd2, 16'h0033, 1'b1);
        dout_ready = 1'b1;
        trigger();
        #1;
        total_cnt++;
        if (dout_data !== exp_seq[0]) $display("FAIL ares_e0: got %h want %h", dout_data, exp_seq[0]); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (dout_data !== exp_seq[1]) $display("FAIL ares_e1: got %h want %h", dout_data, exp_seq[1]); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (dout_valid !== 1'b0) $display("FAIL ares_valid_drop: got %b want 0", dout_valid); else pass_cnt++;
        total_cnt++;
        if (din_ready !== 1'b0 || cfg_ready !== 1'b0)
            $display("FAIL ares_ready_low: got din_ready=%b cfg_ready=%b want 0 0", din_ready, cfg_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (din_ready !== 1'b1) $display("FAIL ares_idle: got %b want 1", din_ready); else pass_cnt++;
        trigger();
        #1;
        total_cnt++;
        if (dout_valid !== 1'b1 || dout_data !== 17'h10000)
            $display("FAIL ares_default_seq: got valid=%b data=%h want valid=1 data=10000", dout_valid, dout_data);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (dout_valid !== 1'b0) $display("FAIL ares_default_single: got %b want 0", dout_valid); else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        exp_seq[0] = 17'h00011;
        exp_seq[1] = 17'h00022;
        exp_seq[2] = 17'h10033;
        test_reset();
        test_post_reset_trigger();
        test_burst();
        test_stall();
        test_priority();
        test_cfg_locked();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
